ddr_pair_deframer: RTL
======================

Name: ddr_pair_deframer

Overview:
- Consumes the 2-bit DDR pairs {rising-edge bit, falling-edge bit} recovered from sdr_data in the clk_internal domain.
- Shifts the pairs MSB-first into a search register and locates a fixed sync word at pair granularity.
- Confirms lock over several frames, then emits aligned payload words to the downstream clock-domain-crossing FIFO writer.
- Provides lock status and an error counter for the debug register bank.

Parameters:
- WORD_W, 32: word width in bits; must be even and at least 4. P = WORD_W/2 pairs per word.
- SYNC_WORD, 32'hA5C3_F00F: frame sync pattern, WORD_W bits wide.
- PAYLOAD_WORDS, 15: payload words per frame, following the sync word; must be at least 1.
- VERIFY_FRAMES, 2: consecutive sync hits required after the first detection before lock.
- MISS_LIMIT, 3: consecutive sync misses in LOCKED before lock is dropped.

Ports:
- clk_internal  in  1  internal 190 MHz clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pair_in  in  2  {rise_bit, fall_bit}; rise_bit is earlier in time.
- pair_valid  in  1  pair_in is valid this cycle; single-cycle strobe; no backpressure.
- clear_stats  in  1  synchronous clear of sync_err_cnt.
- word_out  out  WORD_W  aligned payload word; first-received bit at the MSB.
- word_valid  out  1  one-cycle strobe qualifying word_out.
- frame_start  out  1  high together with word_valid on payload word 0 of each frame.
- locked  out  1  high while the state machine is in LOCKED.
- sync_err_cnt  out  16  saturating count of sync misses seen in LOCKED.

Behaviour:
- Reset (async, any state, mid-word or mid-frame): state=HUNT; shift register, pcnt, wcnt, hit and miss counters cleared; word_out=0, word_valid=0, frame_start=0, locked=0, sync_err_cnt=0.
- Shift register: on pair_valid, sr <= {sr[WORD_W-3:0], pair_in}. Cycles with pair_valid=0 change nothing.
- Match: compare the next value of sr to SYNC_WORD.
- HUNT:
  - Check on every pair_valid.
  - On match: go to VERIFY, pcnt=0, wcnt=0, hits=0.
- Framing counters (VERIFY and LOCKED):
  - Each pair_valid increments pcnt.
  - The pair with pcnt==P-1 completes a word and wraps pcnt to 0.
  - A completed word with wcnt<PAYLOAD_WORDS is a payload word; then wcnt++.
  - A completed word with wcnt==PAYLOAD_WORDS is the sync slot; then wcnt=0.
- VERIFY:
  - Payload words are discarded.
  - Sync slot hit: hits++. When hits reaches VERIFY_FRAMES, go to LOCKED (locked=1 next cycle) with miss=0.
  - Sync slot miss: go to HUNT. sync_err_cnt is not touched.
- LOCKED:
  - Payload word: word_out <= completed word; word_valid=1 for exactly one cycle. Latency is 1 cycle after the completing pair_valid.
  - frame_start=1 when wcnt==0.
  - Sync slot hit: miss=0.
  - Sync slot miss: miss++ and sync_err_cnt++ (saturates at 16'hFFFF). Framing is kept (flywheel) and payload continues to be emitted.
  - When miss reaches MISS_LIMIT, go to HUNT; locked=0 next cycle. The mismatching slot itself is not emitted.
- No realignment while in LOCKED: a SYNC_WORD pattern at a wrong offset is ignored.
- clear_stats and a miss increment in the same cycle: the clear wins, so sync_err_cnt=0.
- word_valid and frame_start are 0 in every cycle that does not emit a payload word.

Test Plan (WORD_W=8, SYNC_WORD=8'hB4, PAYLOAD_WORDS=2, VERIFY_FRAMES=2, MISS_LIMIT=3; pair_valid every 3rd cycle):
1. Lock acquisition: two random pairs, then three frames B4,11,22 → locked rises after the third B4. The next frame B4,33,44 gives word_out=33 with frame_start=1, then 44 with frame_start=0, each 1 cycle after its last pair.
2. Bit-offset alignment: same stream preceded by a single pair 2'b01 → identical lock and word values. Pairs 2'b10,2'b11,2'b01,2'b00 → B4 detected at the pair offset.
3. Flywheel: while locked, replace one sync with 8'h00 → sync_err_cnt=1, locked stays 1, payload still emitted. A following correct sync resets the miss count.
4. Loss of lock: three consecutive bad syncs → sync_err_cnt=3, locked=0 after the third, no further word_valid until re-acquired. clear_stats → sync_err_cnt=0.
5. VERIFY failure: B4, then a corrupted sync slot → state returns to HUNT; locked never asserts; sync_err_cnt stays 0.
6. Reset mid-frame: assert rst between pairs 2 and 3 of a payload word while locked → all outputs 0 immediately; re-lock requires three full frames.

Source files
------------

// File: rtl/ddr_pair_deframer_if.sv
// ddr_pair_deframer_if: DDR pair input stream and aligned payload word output bundle
interface ddr_pair_deframer_if #(parameter int WORD_W = 32);
  logic [1:0]        pair_in;
  logic              pair_valid;
  logic              clear_stats;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              frame_start;
  logic              locked;
  logic [15:0]       sync_err_cnt;
  modport master (
    output pair_in, pair_valid, clear_stats,
    input  word_out, word_valid, frame_start, locked, sync_err_cnt
  );
  modport slave (
    input  pair_in, pair_valid, clear_stats,
    output word_out, word_valid, frame_start, locked, sync_err_cnt
  );
endinterface

// File: rtl/ddr_pair_deframer.sv
// ddr_pair_deframer: locates a sync word in a DDR pair stream, confirms lock and emits aligned payload words
module ddr_pair_deframer #(
  parameter int                WORD_W        = 32,
  parameter logic [WORD_W-1:0] SYNC_WORD     = 32'hA5C3_F00F,
  parameter int                PAYLOAD_WORDS = 15,
  parameter int                VERIFY_FRAMES = 2,
  parameter int                MISS_LIMIT    = 3
) (
  input logic               clk_internal,
  input logic               rst,
  ddr_pair_deframer_if.slave bus
);
  localparam int P    = WORD_W / 2;
  localparam int PC_W = $clog2(P);
  localparam int WC_W = $clog2(PAYLOAD_WORDS + 1);
  localparam int HC_W = $clog2(VERIFY_FRAMES + 2);
  localparam int MC_W = $clog2(MISS_LIMIT + 2);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sr, w_sr_nxt;
  logic [PC_W-1:0]   r_pcnt, w_pcnt_nxt;
  logic [WC_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [HC_W-1:0]   r_hits, w_hits_nxt;
  logic [MC_W-1:0]   r_miss, w_miss_nxt;
  logic [15:0]       r_err, w_err_nxt;
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic              r_word_valid, w_word_valid_nxt;
  logic              r_frame_start, w_frame_start_nxt;
  logic              w_hit, w_done, w_slot;
  // The sync compare looks at the shift register as it will be after this pair
  always_comb begin
    w_sr_nxt          = {r_sr[WORD_W-3:0], bus.pair_in};
    w_hit             = w_sr_nxt == SYNC_WORD;
    w_done            = bus.pair_valid && r_state != HUNT && r_pcnt == PC_W'(P - 1);
    w_slot            = r_wcnt == WC_W'(PAYLOAD_WORDS);
    w_state_nxt       = r_state;
    w_pcnt_nxt        = r_pcnt;
    w_wcnt_nxt        = r_wcnt;
    w_hits_nxt        = r_hits;
    w_miss_nxt        = r_miss;
    w_err_nxt         = r_err;
    w_word_nxt        = r_word;
    w_word_valid_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    if (r_state == HUNT) begin
      if (bus.pair_valid && w_hit) begin
        w_state_nxt = VERIFY;
        w_pcnt_nxt  = '0;
        w_wcnt_nxt  = '0;
        w_hits_nxt  = '0;
      end
    end else if (bus.pair_valid) begin
      w_pcnt_nxt = w_done ? '0 : r_pcnt + 1'b1;
      w_wcnt_nxt = !w_done ? r_wcnt : w_slot ? '0 : r_wcnt + 1'b1;
      if (w_done && !w_slot && r_state == LOCKED) begin
        w_word_nxt        = w_sr_nxt;
        w_word_valid_nxt  = 1'b1;
        w_frame_start_nxt = r_wcnt == '0;
      end
      if (w_done && w_slot && r_state == VERIFY) begin
        w_hits_nxt  = r_hits + 1'b1;
        w_miss_nxt  = '0;
        w_state_nxt = !w_hit ? HUNT : (w_hits_nxt == HC_W'(VERIFY_FRAMES)) ? LOCKED : VERIFY;
      end
      // Flywheel: a missed sync keeps framing until MISS_LIMIT misses in a row
      if (w_done && w_slot && r_state == LOCKED) begin
        w_miss_nxt  = w_hit ? '0 : r_miss + 1'b1;
        w_err_nxt   = (w_hit || &r_err) ? r_err : r_err + 16'd1;
        w_state_nxt = (!w_hit && w_miss_nxt == MC_W'(MISS_LIMIT)) ? HUNT : LOCKED;
      end
    end
    if (bus.clear_stats) w_err_nxt = '0;
  end
  always_ff @(posedge clk_internal or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_sr          <= '0;
      r_pcnt        <= '0;
      r_wcnt        <= '0;
      r_hits        <= '0;
      r_miss        <= '0;
      r_err         <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sr          <= bus.pair_valid ? w_sr_nxt : r_sr;
      r_pcnt        <= w_pcnt_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_hits        <= w_hits_nxt;
      r_miss        <= w_miss_nxt;
      r_err         <= w_err_nxt;
      r_word        <= w_word_nxt;
      r_word_valid  <= w_word_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end
  assign bus.word_out     = r_word;
  assign bus.word_valid   = r_word_valid;
  assign bus.frame_start  = r_frame_start;
  assign bus.locked       = r_state == LOCKED;
  assign bus.sync_err_cnt = r_err;
endmodule
